// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 stream scheduler.
package aes_pkg;

  localparam int unsigned AES_LATENCY = 11;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    KSTART,
    KWAIT_LO,
    KWAIT_HI,
    RUN
  } sched_state_e;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer names the requester favoured on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic rr_q;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_id = grant[1];

  // After any transfer, favour the requester that was not served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else if (|grant) begin
      rr_q <= ~grant_id;
    end
  end

endmodule

// File: rtl/aes_stream_scheduler.sv
// Key-expansion sequencing, 2-way block arbitration and response routing for the
// pipelined AES-128 core.
module aes_stream_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned LATENCY = AES_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_busy,
  input  logic [127:0] req0_data,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req1_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  output logic [127:0] rsp0_data,
  output logic         rsp0_valid,
  output logic [127:0] rsp1_data,
  output logic         rsp1_valid,
  output logic         err,
  output logic         aes_start,
  output logic [127:0] aes_key,
  input  logic         aes_key_ready,
  output logic [127:0] aes_data,
  output logic         aes_data_valid,
  input  logic [127:0] aes_out,
  input  logic         aes_done
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  sched_state_e     state_q, state_d;
  tag_t             tag_q [LATENCY];
  tag_t             tail;
  logic [CntW-1:0]  inflight_q;
  logic [1:0]       grant;
  logic             grant_id;
  logic             grant_en;
  logic             xfer;
  logic             key_busy_q;
  logic             aes_start_q;
  logic [127:0]     aes_key_q;
  logic [127:0]     rsp0_data_q, rsp1_data_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic             err_q;

  // key_load takes priority over any request in the same cycle.
  assign grant_en = (state_q == RUN) && !key_load;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .enable   (grant_en),
    .valid    ({req1_valid, req0_valid}),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign xfer           = |grant;
  assign req0_ready     = grant[0];
  assign req1_ready     = grant[1];
  assign aes_data_valid = xfer;
  assign aes_data       = grant_id ? req1_data : req0_data;
  assign tail           = tag_q[LATENCY-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RUN: state_d = state_q;
      DRAIN:     if (inflight_q == '0) state_d = KSTART;
      KSTART:    state_d = KWAIT_LO;
      KWAIT_LO:  if (!aes_key_ready) state_d = KWAIT_HI;
      KWAIT_HI:  if (aes_key_ready) state_d = RUN;
      default:   state_d = IDLE;
    endcase
    if (key_load) state_d = DRAIN;
  end

  // Outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      key_busy_q  <= 1'b0;
      aes_start_q <= 1'b0;
      aes_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_busy_q  <= (state_d != RUN);
      aes_start_q <= (state_d == KSTART);
      if (key_load) aes_key_q <= key_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(LATENCY); i++) tag_q[i] <= '0;
      inflight_q <= '0;
    end else begin
      tag_q[0] <= tag_t'{vld: xfer, id: grant_id};
      for (int i = 1; i < int'(LATENCY); i++) tag_q[i] <= tag_q[i-1];
      unique case ({xfer, tail.vld})
        2'b10:   inflight_q <= inflight_q + CntW'(1);
        2'b01:   inflight_q <= inflight_q - CntW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      if (tail.vld && aes_done) begin
        if (tail.id) begin
          rsp1_data_q  <= aes_out;
          rsp1_valid_q <= 1'b1;
        end else begin
          rsp0_data_q  <= aes_out;
          rsp0_valid_q <= 1'b1;
        end
      end
      // A done without a matching tag (or a missing done) means the core lost sync.
      if (tail.vld != aes_done) err_q <= 1'b1;
    end
  end

  assign key_busy   = key_busy_q;
  assign aes_start  = aes_start_q;
  assign aes_key    = aes_key_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_stream_scheduler.sv
// Directed bench for aes_stream_scheduler with a behavioural 11-stage core and key expander.
module tb_aes_stream_scheduler;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'hfeedfacecafebeef0123456789abcdef;
  localparam logic [127:0] K3 = 128'h3333333333333333cccccccccccccccc;
  localparam logic [127:0] K4 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic         clk, reset;
  logic [127:0] key_in;
  logic         key_load, key_busy;
  logic [127:0] req0_data, req1_data;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0] rsp0_data, rsp1_data;
  logic         rsp0_valid, rsp1_valid, err;
  logic         aes_start, aes_key_ready;
  logic [127:0] aes_key, aes_data, aes_out;
  logic         aes_data_valid, aes_done;
  logic         force_done;

  int total = 0;
  int bad   = 0;
  int rsp0_cnt = 0, rsp1_cnt = 0, start_cnt = 0, rsp_at_start = 0;
  logic [127:0] exp0[$], exp1[$];
  logic [127:0] cur_key, pt0_next, pt1_next;

  aes_stream_scheduler dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load), .key_busy(key_busy),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .rsp0_data(rsp0_data), .rsp0_valid(rsp0_valid), .rsp1_data(rsp1_data),
    .rsp1_valid(rsp1_valid), .err(err), .aes_start(aes_start), .aes_key(aes_key),
    .aes_key_ready(aes_key_ready), .aes_data(aes_data), .aes_data_valid(aes_data_valid),
    .aes_out(aes_out), .aes_done(aes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cipher: the FIPS-197 vector is exact, everything else is pt ^ key.
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key);
    if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
    return pt ^ key;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural core: key latched at aes_start, result emerges 11 edges after load.
  logic [10:0]  core_v;
  logic [127:0] core_d [11];
  logic [127:0] core_key;
  logic [2:0]   kcnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_v   <= '0;
      core_key <= '0;
      kcnt     <= '0;
      for (int i = 0; i < 11; i++) core_d[i] <= '0;
    end else begin
      core_v    <= {core_v[9:0], aes_data_valid};
      core_d[0] <= model_ct(aes_data, core_key);
      for (int i = 1; i < 11; i++) core_d[i] <= core_d[i-1];
      if (aes_start) begin
        kcnt     <= 3'd4;
        core_key <= aes_key;
      end else if (kcnt != 3'd0) begin
        kcnt <= kcnt - 3'd1;
      end
    end
  end

  assign aes_key_ready = (kcnt == 3'd0);
  assign aes_done      = core_v[10] | force_done;
  assign aes_out       = core_d[10];

  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid) begin
        rsp0_cnt++;
        if (exp0.size() == 0) check("rsp0_unexpected", 128'(rsp0_valid), 128'd0);
        else check("rsp0_data", rsp0_data, exp0.pop_front());
      end
      if (rsp1_valid) begin
        rsp1_cnt++;
        if (exp1.size() == 0) check("rsp1_unexpected", 128'(rsp1_valid), 128'd0);
        else check("rsp1_data", rsp1_data, exp1.pop_front());
      end
      if (aes_start) begin
        start_cnt++;
        rsp_at_start = rsp0_cnt + rsp1_cnt;
      end
    end
  end

  // One cycle of stimulus, driven at a falling edge; returns the observed grants.
  task automatic step(input logic v0, input logic v1, input logic kl, input logic [127:0] kin,
                      output logic [1:0] g);
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = pt0_next;
    req1_data  = pt1_next;
    key_load   = kl;
    key_in     = kin;
    #1;
    g = {req1_valid & req1_ready, req0_valid & req0_ready};
    if (g[0]) begin
      exp0.push_back(model_ct(pt0_next, cur_key));
      pt0_next = pt0_next + 128'd1;
    end
    if (g[1]) begin
      exp1.push_back(model_ct(pt1_next, cur_key));
      pt1_next = pt1_next + 128'd1;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    key_load   = 1'b0;
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, g);
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && key_busy; i++) @(negedge clk);
    check("reach_run", 128'(key_busy), 128'd0);
  endtask

  task automatic load_key(input logic [127:0] k);
    logic [1:0] g;
    step(1'b0, 1'b0, 1'b1, k, g);
    cur_key = k;
    wait_run();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp0.delete();
    exp1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]   g;
    logic [127:0] ct;
    int lat, r0, r1, s, rbase;

    reset = 1'b1; key_load = 1'b0; key_in = '0; force_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    cur_key = '0; pt0_next = '0; pt1_next = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_key_busy", 128'(key_busy), 128'd0);
    check("rst_aes_start", 128'(aes_start), 128'd0);
    check("rst_aes_key", aes_key, 128'd0);
    check("rst_req0_ready", 128'(req0_ready), 128'd0);
    check("rst_rsp0_valid", 128'(rsp0_valid), 128'd0);
    check("rst_rsp1_valid", 128'(rsp1_valid), 128'd0);
    check("rst_rsp0_data", rsp0_data, 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_data_valid", 128'(aes_data_valid), 128'd0);
    reset = 1'b0;
    #1;
    check("busy_before_edge", 128'(key_busy), 128'd0);
    @(negedge clk);
    check("busy_after_edge", 128'(key_busy), 128'd1);
    check("idle_req0_ready", 128'(req0_ready), 128'd0);
    req0_valid = 1'b0;

    // First key: DRAIN then a single aes_start cycle
    step(1'b0, 1'b0, 1'b1, FIPS_KEY, g);
    cur_key = FIPS_KEY;
    check("key_captured", aes_key, FIPS_KEY);
    check("start_in_drain", 128'(aes_start), 128'd0);
    @(negedge clk);
    check("start_in_kstart", 128'(aes_start), 128'd1);
    @(negedge clk);
    check("start_after_kstart", 128'(aes_start), 128'd0);
    wait_run();

    // FIPS-197 block on requester 0, 12-cycle end-to-end latency
    pt0_next = FIPS_PT;
    r1 = rsp1_cnt;
    lat = -1;
    ct = '0;
    step(1'b1, 1'b0, 1'b0, '0, g);
    check("fips_grant", 128'(g), 128'd1);
    for (int n = 1; n <= 20; n++) begin
      if (rsp0_valid && lat < 0) begin
        lat = n;
        ct  = rsp0_data;
      end
      @(negedge clk);
    end
    check("fips_latency", 128'(lat), 128'd12);
    check("fips_ct", ct, FIPS_CT);
    check("fips_no_rsp1", 128'(rsp1_cnt), 128'(r1));

    // Both requesters for 20 cycles from a fresh pointer
    do_reset();
    load_key(FIPS_KEY);
    pt0_next = 128'ha0000;
    pt1_next = 128'hb0000;
    r0 = rsp0_cnt;
    r1 = rsp1_cnt;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 1'b0, '0, g);
      check("alt_grant", 128'(g), (k % 2 == 0) ? 128'd1 : 128'd2);
    end
    idle(14);
    check("alt_rsp0_count", 128'(rsp0_cnt - r0), 128'd10);
    check("alt_rsp1_count", 128'(rsp1_cnt - r1), 128'd10);
    check("alt_exp_drained", 128'(exp0.size() + exp1.size()), 128'd0);

    // Rekey with 11 blocks in flight
    rbase = rsp0_cnt + rsp1_cnt;
    s = start_cnt;
    for (int k = 0; k < 11; k++) step(1'b1, 1'b1, 1'b0, '0, g);
    step(1'b1, 1'b1, 1'b1, K2, g);
    check("kl_drops_ready", 128'(g), 128'd0);
    cur_key = K2;
    for (int i = 0; i < 40 && start_cnt == s; i++) @(negedge clk);
    check("drain_start_seen", 128'(start_cnt), 128'(s + 1));
    check("drain_before_start", 128'(rsp_at_start), 128'(rbase + 11));
    wait_run();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, '0, g);
    idle(14);
    check("newkey_exp_drained", 128'(exp0.size() + exp1.size()), 128'd0);

    // key_load beats a request; second key_load in KWAIT_HI restarts expansion
    s = start_cnt;
    step(1'b1, 1'b0, 1'b1, K3, g);
    check("kl_priority", 128'(g), 128'd0);
    cur_key = K3;
    idle(3);
    check("busy_in_kwait", 128'(key_busy), 128'd1);
    step(1'b0, 1'b0, 1'b1, K4, g);
    cur_key = K4;
    wait_run();
    check("restart_two_starts", 128'(start_cnt), 128'(s + 2));
    check("restart_final_key", aes_key, K4);
    step(1'b1, 1'b0, 1'b0, '0, g);
    idle(14);
    check("k4_exp_drained", 128'(exp0.size()), 128'd0);

    // Spurious done with an empty tag pipe
    check("err_before", 128'(err), 128'd0);
    r0 = rsp0_cnt + rsp1_cnt;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    check("err_set", 128'(err), 128'd1);
    idle(3);
    check("err_sticky", 128'(err), 128'd1);
    check("spurious_no_rsp", 128'(rsp0_cnt + rsp1_cnt), 128'(r0));

    // Reset while waiting for the expander
    step(1'b0, 1'b0, 1'b1, K2, g);
    idle(2);
    reset = 1'b1;
    #1;
    check("rst2_err", 128'(err), 128'd0);
    check("rst2_aes_start", 128'(aes_start), 128'd0);
    check("rst2_key_busy", 128'(key_busy), 128'd0);
    check("rst2_aes_key", aes_key, 128'd0);
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_busy_idle", 128'(key_busy), 128'd1);
    req0_valid = 1'b1;
    #1;
    check("rst2_no_grant", 128'(req0_ready), 128'd0);
    req0_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
